// File: rtl/mem_arbiter_if.sv
// Shared access-size type and the tinymemif single-port memory interface
// used by mem_arbiter (read path is combinational within the cycle).
package mem_arbiter_pkg;
   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } mem_access_size_t;
endpackage

interface tinymemif;
   import mem_arbiter_pkg::*;

   logic [31:0]      rd_addr;
   logic [31:0]      rd_data;
   mem_access_size_t rd_size;
   logic [31:0]      wr_addr;
   logic [31:0]      wr_data;
   mem_access_size_t wr_size;
   logic             wr_enable;

   modport mem (
      output rd_addr, rd_size, wr_addr, wr_data, wr_size, wr_enable,
      input  rd_data
   );

   modport slave (
      input  rd_addr, rd_size, wr_addr, wr_data, wr_size, wr_enable,
      output rd_data
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (0 = fetch, 1 = data) arbiter onto one tinymemif memory, one access
// in flight. Define MEM_ARBITER_RR_EN for round-robin ties; default: port 1 wins ties.
module mem_arbiter
   import mem_arbiter_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [1:0]              req_valid,
   output logic [1:0]              req_ready,
   input  logic [1:0][31:0]        req_addr,
   input  logic [1:0][31:0]        req_wdata,
   input  mem_access_size_t [1:0]  req_size,
   input  logic [1:0]              req_we,
   output logic [1:0]              resp_valid,
   input  logic [1:0]              resp_ready,
   output logic [1:0][31:0]        resp_data,
   tinymemif.mem                   mem
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t           state;
   logic [31:0]      lat_addr;
   logic [31:0]      lat_wdata;
   mem_access_size_t lat_size;
   logic             lat_we;
   logic             owner;
   logic [31:0]      resp_q;
`ifdef MEM_ARBITER_RR_EN
   logic             last_grant;
`endif

   logic grant_any;
   logic grant_port;
   logic accept;
   logic issuing;

   // NOTE: every output of an always_comb gets a default on entry; a path that
   // leaves one unassigned would infer a latch.
   always_comb begin
      grant_any  = 1'b0;
      grant_port = 1'b0;
      case (req_valid)
         2'b01: begin
            grant_any  = 1'b1;
            grant_port = 1'b0;
         end
         2'b10: begin
            grant_any  = 1'b1;
            grant_port = 1'b1;
         end
         2'b11: begin
            grant_any  = 1'b1;
`ifdef MEM_ARBITER_RR_EN
            grant_port = ~last_grant;
`else
            grant_port = 1'b1;
`endif
         end
         default: ;
      endcase
   end

   assign accept    = (state == IDLE) && grant_any;
   assign req_ready = accept ? (2'b01 << grant_port) : 2'b00;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: only the handful of control/datapath registers are reset here;
         // there is no memory array in this block to clear.
         state     <= IDLE;
         lat_addr  <= 32'd0;
         lat_wdata <= 32'd0;
         lat_size  <= SIZE_BYTE;
         lat_we    <= 1'b0;
         owner     <= 1'b0;
         resp_q    <= 32'd0;
`ifdef MEM_ARBITER_RR_EN
         last_grant <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  lat_addr  <= req_addr[grant_port];
                  lat_wdata <= req_wdata[grant_port];
                  lat_size  <= req_size[grant_port];
                  lat_we    <= req_we[grant_port];
                  owner     <= grant_port;
`ifdef MEM_ARBITER_RR_EN
                  last_grant <= grant_port;
`endif
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               resp_q <= lat_we ? 32'd0 : mem.rd_data;
               state  <= RESP;
            end
            RESP: begin
               // A ready from the port that does not own the response is ignored.
               if (resp_ready[owner]) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign issuing = (state == ISSUE);

   // The write strobe is gated by reset so an aborted access never commits.
   assign mem.rd_addr   = issuing ? lat_addr  : 32'd0;
   assign mem.wr_addr   = issuing ? lat_addr  : 32'd0;
   assign mem.wr_data   = issuing ? lat_wdata : 32'd0;
   assign mem.rd_size   = lat_size;
   assign mem.wr_size   = lat_size;
   assign mem.wr_enable = issuing & lat_we & ~reset;

   assign resp_valid = (state == RESP) ? (2'b01 << owner) : 2'b00;
   assign resp_data  = {resp_q, resp_q};

endmodule
